// File: rtl/rete_1_if.sv
// Bus bundle for the rete_1 logic network: two network inputs in, the
// registered result plus its change pulse and transition count out.
interface rete_1_if #(
    parameter int CNT_W = 8
);
    logic             a;
    logic             b;
    logic             c;
    logic             c_changed;
    logic [CNT_W-1:0] c_count;

    modport master (
        output a,
        output b,
        input  c,
        input  c_changed,
        input  c_count
    );

    modport slave (
        input  a,
        input  b,
        output c,
        output c_changed,
        output c_count
    );
endinterface

// File: rtl/rete_1.sv
// Two-input Boolean network: synchronized a/b index a 4-entry truth table;
// the registered result c is reported with a change pulse and saturating count.
module rete_1 #(
    parameter logic [3:0] TT          = 4'b0110,
    parameter int         SYNC_STAGES = 2,
    parameter int         CNT_W       = 8
) (
    input  logic     clk,
    input  logic     rst,
    rete_1_if.slave  bus
);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic                   a_s;
    logic                   b_s;
    logic [1:0]             lookup_idx;
    logic                   c_next;
    logic                   c_q;
    logic                   changed_q;
    logic [CNT_W-1:0]       count_q;
    logic                   c_diff;
    logic                   count_full;

    // Independent chains per input; a and b may arrive asynchronously to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync[0] <= bus.a;
            b_sync[0] <= bus.b;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i] <= a_sync[i-1];
                b_sync[i] <= b_sync[i-1];
            end
        end
    end

    assign a_s        = a_sync[SYNC_STAGES-1];
    assign b_s        = b_sync[SYNC_STAGES-1];
    assign lookup_idx = {a_s, b_s};
    assign c_next     = TT[lookup_idx];
    assign c_diff     = (c_next != c_q);
    assign count_full = (count_q == {CNT_W{1'b1}});

    // c resets to 0 rather than TT[0], so a TT[0]=1 table counts its first update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q       <= 1'b0;
            changed_q <= 1'b0;
            count_q   <= '0;
        end else begin
            c_q       <= c_next;
            changed_q <= c_diff;
            if (c_diff && !count_full) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.c         = c_q;
    assign bus.c_changed = changed_q;
    assign bus.c_count   = count_q;

endmodule

// File: tb/tb_rete_1.sv
// Directed bench for rete_1: XOR, AND and constant-one tables driven from
// shared inputs, checked against hand-computed outputs.
module tb_rete_1;

  logic clk;
  logic rst;
  logic a;
  logic b;

  int n_checks = 0;
  int n_errors = 0;

  int pulses_xor = 0;
  int pulses_and = 0;
  int pulses_one = 0;
  int p_xor;
  int p_and;
  int p_one;

  rete_1_if #(.CNT_W(8)) xor_if ();
  rete_1_if #(.CNT_W(8)) and_if ();
  rete_1_if #(.CNT_W(8)) one_if ();

  assign xor_if.a = a;
  assign xor_if.b = b;
  assign and_if.a = a;
  assign and_if.b = b;
  assign one_if.a = a;
  assign one_if.b = b;

  rete_1 #(.TT(4'b0110), .SYNC_STAGES(2), .CNT_W(8)) dut_xor (
    .clk (clk),
    .rst (rst),
    .bus (xor_if)
  );

  rete_1 #(.TT(4'b1000), .SYNC_STAGES(2), .CNT_W(8)) dut_and (
    .clk (clk),
    .rst (rst),
    .bus (and_if)
  );

  rete_1 #(.TT(4'b1111), .SYNC_STAGES(2), .CNT_W(8)) dut_one (
    .clk (clk),
    .rst (rst),
    .bus (one_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // change-pulse accumulators, sampled on the falling edge
  always @(negedge clk) begin
    pulses_xor = pulses_xor + int'(xor_if.c_changed);
    pulses_and = pulses_and + int'(and_if.c_changed);
    pulses_one = pulses_one + int'(one_if.c_changed);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive a/b just after a falling edge and hold for n cycles
  task automatic apply(input logic av, input logic bv, input int n);
    a = av;
    b = bv;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    repeat (3) @(negedge clk);

    // reset state: c held at 0 even for TT[0]=1
    check("rst_xor_c",     32'(xor_if.c),         0);
    check("rst_xor_chg",   32'(xor_if.c_changed), 0);
    check("rst_xor_cnt",   32'(xor_if.c_count),   0);
    check("rst_one_c",     32'(one_if.c),         0);
    check("rst_one_chg",   32'(one_if.c_changed), 0);
    check("rst_one_cnt",   32'(one_if.c_count),   0);
    check("rst_and_cnt",   32'(and_if.c_count),   0);

    // release with a=b=0; constant-one table updates on the first edge
    rst = 1'b0;
    @(negedge clk);
    check("rel_one_c",     32'(one_if.c),         1);
    check("rel_one_chg",   32'(one_if.c_changed), 1);
    check("rel_one_cnt",   32'(one_if.c_count),   1);
    check("rel_xor_c",     32'(xor_if.c),         0);
    repeat (9) @(negedge clk);
    check("idle_xor_c",    32'(xor_if.c),         0);
    check("idle_xor_cnt",  32'(xor_if.c_count),   0);
    check("idle_xor_puls", 32'(pulses_xor),       0);
    check("idle_and_puls", 32'(pulses_and),       0);
    check("idle_one_puls", 32'(pulses_one),       1);
    check("idle_one_chg",  32'(one_if.c_changed), 0);
    check("idle_one_cnt",  32'(one_if.c_count),   1);

    // sweep 00,01,10,11
    p_xor = pulses_xor;
    p_and = pulses_and;
    p_one = pulses_one;
    apply(1'b0, 1'b0, 5);
    check("sw00_xor_c", 32'(xor_if.c), 0);
    check("sw00_and_c", 32'(and_if.c), 0);
    apply(1'b0, 1'b1, 5);
    check("sw01_xor_c", 32'(xor_if.c), 1);
    check("sw01_and_c", 32'(and_if.c), 0);
    apply(1'b1, 1'b0, 5);
    check("sw10_xor_c", 32'(xor_if.c), 1);
    check("sw10_and_c", 32'(and_if.c), 0);
    check("sw10_xor_cnt", 32'(xor_if.c_count), 1);
    // 11: AND rises (and XOR falls) exactly on the third edge
    apply(1'b1, 1'b1, 1);
    check("lat1_and_c", 32'(and_if.c), 0);
    @(negedge clk);
    check("lat2_and_c", 32'(and_if.c), 0);
    check("lat2_xor_c", 32'(xor_if.c), 1);
    @(negedge clk);
    check("lat3_and_c",   32'(and_if.c),         1);
    check("lat3_and_chg", 32'(and_if.c_changed), 1);
    check("lat3_xor_c",   32'(xor_if.c),         0);
    repeat (2) @(negedge clk);
    check("sw_xor_cnt",  32'(xor_if.c_count),   2);
    check("sw_and_cnt",  32'(and_if.c_count),   1);
    check("sw_one_cnt",  32'(one_if.c_count),   1);
    check("sw_one_c",    32'(one_if.c),         1);
    check("sw_xor_puls", 32'(pulses_xor - p_xor), 2);
    check("sw_and_puls", 32'(pulses_and - p_and), 1);
    check("sw_one_puls", 32'(pulses_one - p_one), 0);

    // build up c=1, count=5 on XOR, then reset mid-cycle
    apply(1'b1, 1'b0, 5);
    check("pre_and_cnt", 32'(and_if.c_count), 2);
    apply(1'b0, 1'b0, 5);
    apply(1'b1, 1'b0, 5);
    check("pre_xor_c",   32'(xor_if.c),       1);
    check("pre_xor_cnt", 32'(xor_if.c_count), 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_xor_c",   32'(xor_if.c),         0);
    check("arst_xor_chg", 32'(xor_if.c_changed), 0);
    check("arst_xor_cnt", 32'(xor_if.c_count),   0);
    check("arst_and_cnt", 32'(and_if.c_count),   0);
    check("arst_one_c",   32'(one_if.c),         0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rec2_xor_c", 32'(xor_if.c), 0);
    @(negedge clk);
    check("rec3_xor_c",   32'(xor_if.c),         1);
    check("rec3_xor_chg", 32'(xor_if.c_changed), 1);
    check("rec3_xor_cnt", 32'(xor_if.c_count),   1);
    check("rec3_one_c",   32'(one_if.c),         1);
    check("rec3_one_cnt", 32'(one_if.c_count),   1);
    check("rec3_and_c",   32'(and_if.c),         0);
    check("rec3_and_cnt", 32'(and_if.c_count),   0);
    @(negedge clk);

    // saturation: 300 toggles of a with b=0, XOR count starts at 1
    for (int k = 1; k <= 300; k++) begin
      apply(~a, 1'b0, 4);
      if (k == 100) check("sat100_cnt", 32'(xor_if.c_count), 101);
      if (k == 250) p_xor = pulses_xor;
      if (k == 260) check("sat260_cnt", 32'(xor_if.c_count), 255);
    end
    check("sat_xor_cnt",  32'(xor_if.c_count),      255);
    check("sat_xor_c",    32'(xor_if.c),            1);
    check("sat_xor_puls", 32'(pulses_xor - p_xor),  50);
    check("sat_and_cnt",  32'(and_if.c_count),      0);
    check("sat_and_c",    32'(and_if.c),            0);
    check("sat_one_cnt",  32'(one_if.c_count),      1);
    check("sat_one_c",    32'(one_if.c),            1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
